// File: rtl/library_replay_if.sv
// Slot-replay bus: request/abort, library RAM read port, coordinate stream and status.
// The slave modport is the replay block; the master modport is its surroundings.
interface library_replay_if #(
  parameter int SLOT_W  = 5,
  parameter int IDX_W   = 11,
  parameter int COORD_W = 5
);
  logic                      i_start;
  logic [SLOT_W-1:0]         i_slot;
  logic                      i_abort;
  logic                      o_rd_en;
  logic [SLOT_W+IDX_W-1:0]   o_addr;
  logic [2*COORD_W-1:0]      i_rd_data;
  logic                      o_valid;
  logic                      i_ready;
  logic [COORD_W-1:0]        o_x;
  logic [COORD_W-1:0]        o_y;
  logic                      o_busy;
  logic                      o_done;
  logic [IDX_W:0]            o_len;

  modport slave (
    input  i_start, i_slot, i_abort, i_rd_data, i_ready,
    output o_rd_en, o_addr, o_valid, o_x, o_y, o_busy, o_done, o_len
  );

  modport master (
    output i_start, i_slot, i_abort, i_rd_data, i_ready,
    input  o_rd_en, o_addr, o_valid, o_x, o_y, o_busy, o_done, o_len
  );
endinterface

// File: rtl/library_replay.sv
// Streams the stored (x,y) words of one library slot back out of the library RAM,
// stopping on a zero terminator word or after the last entry of the slot.
module library_replay #(
  parameter int SLOTS   = 26,
  parameter int SLOT_W  = 5,
  parameter int IDX_W   = 11,
  parameter int COORD_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  library_replay_if.slave    bus
);
  localparam int WORD_W = 2 * COORD_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IDX_W-1:0]  IDX_LAST = {IDX_W{1'b1}};
  localparam logic [SLOT_W:0]   SLOT_LIM = (SLOT_W + 1)'(SLOTS);

  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic [SLOT_W-1:0]   slot_r;
  logic [IDX_W-1:0]    idx_r;
  logic                stop_r;
  logic                term_r;
  logic                inflight_r;
  logic [1:0]          cnt_r;
  logic [WORD_W-1:0]   buf0_r;
  logic [WORD_W-1:0]   buf1_r;
  logic [IDX_W:0]      len_r;

  logic                active_s;
  logic                abort_s;
  logic                start_ok_s;
  logic                slot_ok_s;
  logic                term_now_s;
  logic                push_s;
  logic                valid_s;
  logic                pop_s;
  logic [2:0]          occ_s;
  logic                rd_en_s;
  logic                stop_set_s;

  assign active_s   = (state_r == S_RUN) || (state_r == S_DRAIN);
  assign abort_s    = bus.i_abort && (state_r != S_IDLE);
  assign start_ok_s = (state_r == S_IDLE) && bus.i_start && !bus.i_abort;
  assign slot_ok_s  = ({1'b0, bus.i_slot} < SLOT_LIM);

  // Once a terminator has been seen, every later returning word is dropped.
  assign term_now_s = active_s && inflight_r && !term_r && (bus.i_rd_data == {WORD_W{1'b0}});
  assign push_s     = active_s && inflight_r && !term_r && !term_now_s && !abort_s;
  assign valid_s    = (cnt_r != 2'd0);
  assign pop_s      = valid_s && bus.i_ready;

  // Occupancy after this cycle's pop: allows one issue per cycle while the consumer keeps up.
  assign occ_s      = {1'b0, cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign rd_en_s    = (state_r == S_RUN) && !stop_r && !term_now_s && !bus.i_abort
                      && (occ_s < 3'd2);
  assign stop_set_s = term_now_s || (rd_en_s && (idx_r == IDX_LAST));

  // Next-state logic of the replay controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_ok_s) begin
          state_nxt_s = slot_ok_s ? S_RUN : S_DONE;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort_s) begin
          state_nxt_s = S_IDLE;
        end else if (stop_set_s) begin
          state_nxt_s = S_DRAIN;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DRAIN: begin
        if (abort_s) begin
          state_nxt_s = S_IDLE;
        end else if (!inflight_r && (cnt_r == 2'd0)) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_DRAIN;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Read issue bookkeeping: slot, entry index, stop/terminator flags, read in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_r     <= {SLOT_W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      stop_r     <= 1'b0;
      term_r     <= 1'b0;
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= rd_en_s;
      if (start_ok_s) begin
        slot_r <= bus.i_slot;
        idx_r  <= {IDX_W{1'b0}};
        stop_r <= 1'b0;
        term_r <= 1'b0;
      end else begin
        if (rd_en_s && (idx_r != IDX_LAST)) begin
          idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end
        if (stop_set_s) begin
          stop_r <= 1'b1;
        end
        if (term_now_s) begin
          term_r <= 1'b1;
        end
      end
    end
  end

  // Two-entry output FIFO; buf0_r is always the head.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r  <= 2'd0;
      buf0_r <= {WORD_W{1'b0}};
      buf1_r <= {WORD_W{1'b0}};
    end else if (abort_s || start_ok_s) begin
      cnt_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (cnt_r == 2'd0) begin
            buf0_r <= bus.i_rd_data;
            cnt_r  <= 2'd1;
          end else begin
            buf1_r <= bus.i_rd_data;
            cnt_r  <= 2'd2;
          end
        end
        2'b01: begin
          buf0_r <= buf1_r;
          cnt_r  <= cnt_r - 2'd1;
        end
        2'b11: begin
          if (cnt_r == 2'd1) begin
            buf0_r <= bus.i_rd_data;
          end else begin
            buf0_r <= buf1_r;
            buf1_r <= bus.i_rd_data;
          end
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Handed-over coordinate count; held after completion or abort until the next start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      len_r <= {(IDX_W+1){1'b0}};
    end else if (start_ok_s) begin
      len_r <= {(IDX_W+1){1'b0}};
    end else if (pop_s) begin
      len_r <= len_r + {{IDX_W{1'b0}}, 1'b1};
    end else begin
      len_r <= len_r;
    end
  end

  assign bus.o_rd_en = rd_en_s;
  assign bus.o_addr  = {slot_r, idx_r};
  assign bus.o_valid = valid_s;
  assign bus.o_x     = valid_s ? buf0_r[WORD_W-1:COORD_W] : {COORD_W{1'b0}};
  assign bus.o_y     = valid_s ? buf0_r[COORD_W-1:0]      : {COORD_W{1'b0}};
  assign bus.o_busy  = (state_r != S_IDLE);
  assign bus.o_done  = (state_r == S_DONE);
  assign bus.o_len   = len_r;

endmodule

// File: tb/tb_library_replay.sv
// Directed bench for library_replay: a behavioural library RAM plus hand-computed expectations.
module tb_library_replay;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  library_replay_if #(.SLOT_W(5), .IDX_W(11), .COORD_W(5)) bus ();

  library_replay #(.SLOTS(26), .SLOT_W(5), .IDX_W(11), .COORD_W(5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic [9:0]  mem [0:65535];
  logic [9:0]  got_q [$];
  logic [15:0] addr_q [$];
  int          done_cnt = 0;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [9:0] exp25(input int i);
    return 10'((i % 1023) + 1);
  endfunction

  // RAM model with one-cycle read latency, plus stream/read/done monitors.
  always @(posedge clk) begin
    if (bus.o_rd_en) begin
      bus.i_rd_data <= mem[bus.o_addr];
      addr_q.push_back(bus.o_addr);
    end
    if (bus.o_valid && bus.i_ready) got_q.push_back({bus.o_x, bus.o_y});
    if (bus.o_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [4:0] s);
    bus.i_slot  = s;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n;
    n = 0;
    while (bus.o_busy && n < max) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    int gb, ab, db, n, bad;
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_slot  = 5'd0;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 10'd0;
    mem[3*2048 + 0] = {5'd1, 5'd2};
    mem[3*2048 + 1] = {5'd3, 5'd4};
    for (int i = 0; i < 2048; i++) mem[25*2048 + i] = exp25(i);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(bus.o_busy),  32'd0);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_rd_en", 32'(bus.o_rd_en), 32'd0);
    chk("rst_done",  32'(bus.o_done),  32'd0);
    chk("rst_len",   32'(bus.o_len),   32'd0);
    chk("rst_x",     32'(bus.o_x),     32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // abort alone and start+abort in IDLE are ignored
    bus.i_abort = 1'b1;
    @(negedge clk);
    chk("idle_abort_busy", 32'(bus.o_busy), 32'd0);
    bus.i_slot  = 5'd3;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    chk("start_abort_busy",  32'(bus.o_busy),  32'd0);
    chk("start_abort_rd_en", 32'(bus.o_rd_en), 32'd0);

    // T1: slot 3, ready high
    gb = got_q.size(); ab = addr_q.size(); db = done_cnt;
    do_start(5'd3);
    chk("t1_rd0_en",   32'(bus.o_rd_en), 32'd1);
    chk("t1_rd0_addr", 32'(bus.o_addr),  32'h1800);
    chk("t1_valid_n1", 32'(bus.o_valid), 32'd0);
    @(negedge clk);
    chk("t1_rd1_addr", 32'(bus.o_addr),  32'h1801);
    chk("t1_valid_n2", 32'(bus.o_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_n3", 32'(bus.o_valid), 32'd1);
    chk("t1_x0",       32'(bus.o_x),     32'd1);
    chk("t1_y0",       32'(bus.o_y),     32'd2);
    wait_idle("t1", 50);
    chk("t1_nreads",  32'(addr_q.size() - ab), 32'd3);
    chk("t1_rd2_addr", 32'(addr_q[ab+2]),     32'h1802);
    chk("t1_ncoord",  32'(got_q.size() - gb), 32'd2);
    chk("t1_w0",      32'(got_q[gb]),         32'h022);
    chk("t1_w1",      32'(got_q[gb+1]),       32'h064);
    chk("t1_done",    32'(done_cnt - db),     32'd1);
    chk("t1_len",     32'(bus.o_len),         32'd2);

    // T2: slot 3, consumer stalls 5 cycles at first o_valid
    bus.i_ready = 1'b0;
    gb = got_q.size(); ab = addr_q.size(); db = done_cnt;
    do_start(5'd3);
    n = 0;
    while (!bus.o_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t2_first_valid", 32'(bus.o_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("t2_hold_valid", 32'(bus.o_valid), 32'd1);
      chk("t2_hold_x",     32'(bus.o_x),     32'd1);
      chk("t2_hold_y",     32'(bus.o_y),     32'd2);
      @(negedge clk);
    end
    chk("t2_stall_reads", 32'(addr_q.size() - ab), 32'd2);
    bus.i_ready = 1'b1;
    wait_idle("t2", 50);
    chk("t2_ncoord", 32'(got_q.size() - gb), 32'd2);
    chk("t2_w0",     32'(got_q[gb]),         32'h022);
    chk("t2_w1",     32'(got_q[gb+1]),       32'h064);
    chk("t2_done",   32'(done_cnt - db),     32'd1);
    chk("t2_len",    32'(bus.o_len),         32'd2);

    // T3: slot 25, full 2048-entry slot without terminator
    gb = got_q.size(); ab = addr_q.size(); db = done_cnt;
    do_start(5'd25);
    wait_idle("t3", 2300);
    chk("t3_ncoord", 32'(got_q.size() - gb),  32'd2048);
    chk("t3_nreads", 32'(addr_q.size() - ab), 32'd2048);
    chk("t3_last_addr", 32'(addr_q[addr_q.size()-1]), 32'hCFFF);
    bad = 0;
    for (int i = 0; i < 2048 && (gb + i) < got_q.size(); i++) begin
      if (got_q[gb+i] !== exp25(i)) bad++;
    end
    chk("t3_data_errs", 32'(bad), 32'd0);
    chk("t3_done", 32'(done_cnt - db), 32'd1);
    chk("t3_len",  32'(bus.o_len),     32'd2048);

    // T4: out-of-range slot goes straight to DONE
    ab = addr_q.size(); db = done_cnt;
    do_start(5'd31);
    chk("t4_done_n1", 32'(bus.o_done),  32'd1);
    chk("t4_busy_n1", 32'(bus.o_busy),  32'd1);
    chk("t4_rd_en",   32'(bus.o_rd_en), 32'd0);
    @(negedge clk);
    chk("t4_busy_n2", 32'(bus.o_busy),  32'd0);
    chk("t4_nreads",  32'(addr_q.size() - ab), 32'd0);
    chk("t4_done",    32'(done_cnt - db), 32'd1);
    chk("t4_len",     32'(bus.o_len),     32'd0);

    // T5: slot 0 whose first word is the terminator
    gb = got_q.size(); db = done_cnt;
    do_start(5'd0);
    wait_idle("t5", 50);
    chk("t5_ncoord", 32'(got_q.size() - gb), 32'd0);
    chk("t5_done",   32'(done_cnt - db),     32'd1);
    chk("t5_len",    32'(bus.o_len),         32'd0);

    // T6: abort after three handshakes
    gb = got_q.size(); db = done_cnt;
    do_start(5'd25);
    n = 0;
    while ((got_q.size() - gb) < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_pre_abort_n", 32'(got_q.size() - gb), 32'd3);
    bus.i_abort = 1'b1;
    bus.i_ready = 1'b0;
    @(negedge clk);
    bus.i_abort = 1'b0;
    chk("t6_valid", 32'(bus.o_valid), 32'd0);
    chk("t6_busy",  32'(bus.o_busy),  32'd0);
    chk("t6_x",     32'(bus.o_x),     32'd0);
    chk("t6_len",   32'(bus.o_len),   32'd3);
    repeat (5) @(negedge clk);
    chk("t6_no_done", 32'(done_cnt - db),     32'd0);
    chk("t6_ncoord",  32'(got_q.size() - gb), 32'd3);
    chk("t6_w2",      32'(got_q[gb+2]),       32'(exp25(2)));

    // T7: fresh replay of slot 3 after the abort
    bus.i_ready = 1'b1;
    gb = got_q.size(); db = done_cnt;
    do_start(5'd3);
    wait_idle("t7", 50);
    chk("t7_ncoord", 32'(got_q.size() - gb), 32'd2);
    chk("t7_w0",     32'(got_q[gb]),         32'h022);
    chk("t7_w1",     32'(got_q[gb+1]),       32'h064);
    chk("t7_done",   32'(done_cnt - db),     32'd1);
    chk("t7_len",    32'(bus.o_len),         32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
